// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter for the single unified memory port. Port 0 (core) is
//   the multi-cycle core whose control FSM stalls while core_gnt is low; port 1
//   (aux) is a boot loader / debug writer. The grant is combinational in the
//   request cycle and the memory bus mirrors the granted port. Read data comes
//   back one cycle after the grant, tagged to the issuing port by a one-cycle
//   rvalid pulse.
//
// Handshake: a requester raises req with stable we/addr/wdata/funct3 and holds
//   them until it samples its gnt high at a rising clk edge; that edge is the
//   transfer. For a read (we=0), the issuing port's rvalid is high for exactly
//   the following cycle with rdata valid; rdata is 0 whenever no rvalid is high.
//   Writes never produce rvalid. Nothing is buffered inside the arbiter.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   core_* / aux_*                request, we, addr, wdata, funct3 per port
//   aux_lock                      aux keeps ownership while held with aux_req
//   core_gnt, aux_gnt             access issued this cycle (combinational)
//   core_rvalid, aux_rvalid       read data valid for that port this cycle
//   rdata                         shared read data
//   mem_wren/funct3/addr/wdata    memory request side
//   mem_rd                        memory read data, one cycle after the address
//   dbg_last_owner, dbg_run_cnt,
//   dbg_lock_active, dbg_rd_pend  registered arbiter state for observation
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_CORE_RUN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic              core_gnt,
  output logic              core_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [2:0]        aux_funct3,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wren,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              dbg_last_owner,
  output logic [3:0]        dbg_run_cnt,
  output logic              dbg_lock_active,
  output logic              dbg_rd_pend
);

  localparam logic [0:0] OWNER_CORE = 1'b0;
  localparam logic [0:0] OWNER_AUX  = 1'b1;
  localparam logic [3:0] MAX_RUN    = 4'(MAX_CORE_RUN);
  localparam logic [2:0] IDLE_F3    = 3'b010;

  logic [0:0] last_owner;
  logic [3:0] run_cnt;
  logic       lock_active;
  logic       rd_pend;
  logic [0:0] rd_tag;

  logic       aux_wins;
  logic       issue_rd;
  logic [3:0] run_cnt_nxt;
  logic       lock_nxt;

  // Aux wins when it holds a lock, is the only requester, or the core has
  // used up its run. Grants are forced low while reset is asserted.
  always_comb begin
    aux_wins = aux_req & (lock_active | ~core_req | (run_cnt >= MAX_RUN));
    aux_gnt  = reset_n & aux_wins;
    core_gnt = reset_n & core_req & ~aux_wins;
  end

  always_comb begin
    mem_wren   = 1'b0;
    mem_funct3 = IDLE_F3;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (aux_gnt) begin
      mem_wren   = aux_we;
      mem_funct3 = aux_funct3;
      mem_addr   = aux_addr;
      mem_wdata  = aux_wdata;
    end else if (core_gnt) begin
      mem_wren   = core_we;
      mem_funct3 = core_funct3;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
    end
  end

  assign issue_rd = (core_gnt & ~core_we) | (aux_gnt & ~aux_we);

  always_comb begin
    run_cnt_nxt = run_cnt;
    if (core_gnt && aux_req) begin
      if (run_cnt < MAX_RUN) run_cnt_nxt = run_cnt + 4'd1;
    end else if (aux_gnt || !aux_req) begin
      run_cnt_nxt = 4'd0;
    end
  end

  always_comb begin
    lock_nxt = lock_active;
    if (aux_gnt && aux_lock)       lock_nxt = 1'b1;
    else if (!aux_lock || !aux_req) lock_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner  <= OWNER_CORE;
      run_cnt     <= 4'd0;
      lock_active <= 1'b0;
      rd_pend     <= 1'b0;
      rd_tag      <= OWNER_CORE;
    end else begin
      run_cnt     <= run_cnt_nxt;
      lock_active <= lock_nxt;
      rd_pend     <= issue_rd;
      rd_tag      <= aux_gnt ? OWNER_AUX : OWNER_CORE;
      if (aux_gnt)       last_owner <= OWNER_AUX;
      else if (core_gnt) last_owner <= OWNER_CORE;
    end
  end

  assign core_rvalid = rd_pend & (rd_tag == OWNER_CORE);
  assign aux_rvalid  = rd_pend & (rd_tag == OWNER_AUX);
  assign rdata       = rd_pend ? mem_rd : '0;

  assign dbg_last_owner  = last_owner;
  assign dbg_run_cnt     = run_cnt;
  assign dbg_lock_active = lock_active;
  assign dbg_rd_pend     = rd_pend;

endmodule
